// File: rtl/boot_loader_pkg.sv
// Shared types and constants for the boot_loader byte-stream program loader.
// The checksum feature is selected with the BOOT_LOADER_CHECKSUM_EN macro.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_CHECK,
        S_HOLD,
        S_RUN,
        S_ERROR
    } boot_state_t;

    localparam int HDR_BYTES      = 2;
    localparam int CHECKSUM_WIDTH = 8;

    // States in which the loader is willing to take a byte from the stream.
    function automatic logic accepts_bytes(input boot_state_t s);
        return (s == S_HDR_HI) || (s == S_HDR_LO) || (s == S_DATA) || (s == S_CHECK);
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Assembles a big-endian byte stream into DATA_WIDTH-bit words and flags
// the cycle in which the final byte of a word is shifted in.
module byte_packer
    import boot_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear_i,
    input  logic                  shift_i,
    input  logic [7:0]            byte_i,
    output logic                  word_valid_o,
    output logic [DATA_WIDTH-1:0] word_o
);

    localparam int         BYTES     = DATA_WIDTH / 8;
    localparam logic [3:0] LAST_BYTE = 4'(BYTES - 1);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (shift_i) begin
            cnt_d = (cnt_q == LAST_BYTE) ? 4'd0 : cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign word_valid_o = shift_i && (cnt_q == LAST_BYTE);

    // The word is presented combinationally so the top can register the write
    // on the same edge that accepts the final byte.
    generate
        if (BYTES == 1) begin : g_single
            assign word_o = byte_i;
        end else begin : g_multi
            logic [DATA_WIDTH-9:0] prev_q;

            assign word_o = {prev_q, byte_i};

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    prev_q <= '0;
                end else if (shift_i) begin
                    prev_q <= word_o[DATA_WIDTH-9:0];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/boot_loader.sv
// Streams a program image into memory and holds the CPU in reset until done.
// Define BOOT_LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int MEM_DEPTH     = 4096,
    parameter int ADDR_WIDTH    = $clog2(MEM_DEPTH),
    parameter int DATA_WIDTH    = 16,
    parameter int RELEASE_DELAY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    input  logic                  reload,
    output logic                  mem_en,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam boot_state_t POST_DATA = S_CHECK;
`else
    localparam boot_state_t POST_DATA = S_HOLD;
`endif

    localparam logic [31:0] REL_LAST = 32'(RELEASE_DELAY - 1);

    boot_state_t state_q, state_d;

    logic                  accept;
    logic                  reload_take;
    logic                  word_valid;
    logic [DATA_WIDTH-1:0] word;
    logic                  last_word;
    logic [16:0]           hdr_count;
    logic [16:0]           word_cnt_next;

    logic [7:0]            hdr_hi_q, hdr_hi_d;
    logic [15:0]           count_q, count_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [16:0]           word_cnt_q, word_cnt_d;
    logic [31:0]           rel_cnt_q, rel_cnt_d;

    logic                  in_ready_q, in_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

`ifdef BOOT_LOADER_CHECKSUM_EN
    logic [CHECKSUM_WIDTH-1:0] sum_q, sum_d, sum_next;
`endif

    assign accept        = in_valid && in_ready_q;
    assign reload_take   = reload && ((state_q == S_RUN) || (state_q == S_ERROR));
    assign hdr_count     = {1'b0, hdr_hi_q, in_data};
    assign word_cnt_next = word_cnt_q + 17'd1;
    assign last_word     = (word_cnt_next == {1'b0, count_q});

    byte_packer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (reload_take),
        .shift_i      (accept && (state_q == S_DATA)),
        .byte_i       (in_data),
        .word_valid_o (word_valid),
        .word_o       (word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_HDR_HI;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HDR_HI: begin
                if (accept) state_d = S_HDR_LO;
            end
            S_HDR_LO: begin
                if (accept) begin
                    if (hdr_count > 17'(MEM_DEPTH)) begin
                        state_d = S_ERROR;
                    end else if (hdr_count == 17'd0) begin
                        state_d = POST_DATA;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (word_valid && last_word) state_d = POST_DATA;
            end
            S_CHECK: begin
`ifdef BOOT_LOADER_CHECKSUM_EN
                if (accept) state_d = (sum_next == '0) ? S_HOLD : S_ERROR;
`else
                state_d = S_HOLD;
`endif
            end
            S_HOLD: begin
                if (rel_cnt_q == REL_LAST) state_d = S_RUN;
            end
            S_RUN, S_ERROR: begin
                if (reload_take) state_d = S_HDR_HI;
            end
            default: state_d = S_HDR_HI;
        endcase
    end

    // Outputs are computed from the next state so that every port is a flop
    // and still changes on the same edge as the state it reflects.
    always_comb begin
        in_ready_d  = accepts_bytes(state_d);
        mem_we_d    = word_valid;
        mem_addr_d  = word_valid ? waddr_q : mem_addr_q;
        mem_din_d   = word_valid ? word : mem_din_q;
        cpu_reset_d = (state_d != S_RUN);
        done_d      = (state_d == S_RUN);
        error_d     = (state_d == S_ERROR);
    end

    always_comb begin
        hdr_hi_d   = hdr_hi_q;
        count_d    = count_q;
        waddr_d    = waddr_q;
        word_cnt_d = word_cnt_q;
        rel_cnt_d  = (state_q == S_HOLD) ? rel_cnt_q + 32'd1 : 32'd0;
        if (reload_take) begin
            waddr_d    = '0;
            word_cnt_d = '0;
        end else begin
            if (accept && (state_q == S_HDR_HI)) hdr_hi_d = in_data;
            if (accept && (state_q == S_HDR_LO)) count_d = hdr_count[15:0];
            if (word_valid) begin
                waddr_d    = waddr_q + ADDR_WIDTH'(1);
                word_cnt_d = word_cnt_next;
            end
        end
    end

`ifdef BOOT_LOADER_CHECKSUM_EN
    // Running sum covers header, payload and the checksum byte itself.
    assign sum_next = sum_q + in_data;

    always_comb begin
        sum_d = sum_q;
        if (reload_take) begin
            sum_d = '0;
        end else if (accept) begin
            sum_d = sum_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hdr_hi_q   <= '0;
            count_q    <= '0;
            waddr_q    <= '0;
            word_cnt_q <= '0;
            rel_cnt_q  <= '0;
        end else begin
            hdr_hi_q   <= hdr_hi_d;
            count_q    <= count_d;
            waddr_q    <= waddr_d;
            word_cnt_q <= word_cnt_d;
            rel_cnt_q  <= rel_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_en    = mem_we_q;
    assign mem_wr_en = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign cpu_reset = cpu_reset_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: random and directed images checked against an
// image-level model; honours BOOT_LOADER_CHECKSUM_EN like the design.
module tb_boot_loader;

    localparam int MEM_DEPTH     = 4096;
    localparam int ADDR_WIDTH    = 12;
    localparam int DATA_WIDTH    = 16;
    localparam int RELEASE_DELAY = 2;
    localparam int BPW           = DATA_WIDTH / 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  in_valid = 1'b0;
    logic [7:0]            in_data = 8'h00;
    logic                  reload = 1'b0;
    logic                  in_ready;
    logic                  mem_en;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din;
    logic                  cpu_reset;
    logic                  done;
    logic                  error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  img[$];
    logic [63:0] expW[$];
    bit          expErr;

    logic [63:0] wAddrQ[$];
    logic [63:0] wDataQ[$];
    int          pulseBad = 0;
    int          lastWrCyc = -1;
    int          fallCyc = -1;
    int          lastAcceptCyc = -1;
    logic        prevCpuReset = 1'b1;

    boot_loader #(
        .MEM_DEPTH     (MEM_DEPTH),
        .ADDR_WIDTH    (ADDR_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .RELEASE_DELAY (RELEASE_DELAY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .reload    (reload),
        .mem_en    (mem_en),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor: collects write pulses and the CPU release moment.
    always @(negedge clk) begin
        if (mem_en || mem_wr_en) begin
            if (mem_en !== mem_wr_en) pulseBad++;
            wAddrQ.push_back(64'(mem_addr));
            wDataQ.push_back(64'(mem_din));
            lastWrCyc = cyc;
        end
        if (prevCpuReset && !cpu_reset) fallCyc = cyc;
        prevCpuReset = cpu_reset;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        checkOutput({tag, "_mem_en"}, 64'(mem_en), 64'd0);
        checkOutput({tag, "_mem_wr_en"}, 64'(mem_wr_en), 64'd0);
        checkOutput({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        checkOutput({tag, "_mem_din"}, 64'(mem_din), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_error"}, 64'(error), 64'd0);
    endtask

    task automatic clearMonitor();
        wAddrQ.delete();
        wDataQ.delete();
        pulseBad = 0;
        lastWrCyc = -1;
        fallCyc = -1;
        lastAcceptCyc = -1;
    endtask

    task automatic appendChecksum();
        logic [7:0] s;
        s = 8'h00;
        foreach (img[i]) s = s + img[i];
        img.push_back(8'h00 - s);
    endtask

    task automatic makeImage(input int n);
        img.delete();
        img.push_back(8'(n >> 8));
        img.push_back(8'(n));
        for (int i = 0; i < n * BPW; i++) img.push_back(8'($urandom_range(255, 0)));
`ifdef BOOT_LOADER_CHECKSUM_EN
        appendChecksum();
`endif
    endtask

    // Reference model: what the image should do, straight from the format rules.
    task automatic buildExpect();
        int n;
        logic [7:0] s;
        logic [63:0] w;
        expW.delete();
        expErr = 1'b0;
        n = (int'(img[0]) << 8) | int'(img[1]);
        if (n > MEM_DEPTH) begin
            expErr = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                w = 64'd0;
                for (int b = 0; b < BPW; b++) w = (w << 8) | 64'(img[2 + i * BPW + b]);
                expW.push_back(w);
            end
`ifdef BOOT_LOADER_CHECKSUM_EN
            s = 8'h00;
            foreach (img[i]) s = s + img[i];
            if (s != 8'h00) expErr = 1'b1;
`else
            s = 8'h00;
`endif
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b, input int maxGap, input bit waitReady);
        int g;
        int t;
        g = (maxGap > 0) ? int'($urandom_range(maxGap, 0)) : 0;
        in_valid = 1'b0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (waitReady && !in_ready && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (waitReady && t >= 50) checkOutput("ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        if (waitReady) lastAcceptCyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic sendImage(input int maxGap);
        foreach (img[i]) applyStimulus(img[i], maxGap, 1'b1);
    endtask

    task automatic checkLoad(input string tag);
        int t;
        buildExpect();
        t = 0;
        while (!done && !error && t < RELEASE_DELAY + 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput({tag, "_wr_count"}, 64'(wAddrQ.size()), 64'(expW.size()));
        for (int i = 0; i < expW.size(); i++) begin
            if (i < wAddrQ.size()) begin
                checkOutput($sformatf("%s_addr%0d", tag, i), wAddrQ[i], 64'(i));
                checkOutput($sformatf("%s_data%0d", tag, i), wDataQ[i], expW[i]);
            end
        end
        checkOutput({tag, "_pulse_pair"}, 64'(pulseBad), 64'd0);
        checkOutput({tag, "_done"}, 64'(done), 64'(!expErr));
        checkOutput({tag, "_error"}, 64'(error), 64'(expErr));
        checkOutput({tag, "_cpu_reset"}, 64'(cpu_reset), 64'(expErr));
        checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        if (!expErr) begin
            checkOutput({tag, "_release_delay"}, 64'(fallCyc - lastAcceptCyc), 64'(RELEASE_DELAY));
`ifndef BOOT_LOADER_CHECKSUM_EN
            if (expW.size() > 0) checkOutput({tag, "_write_latency"}, 64'(lastWrCyc), 64'(lastAcceptCyc));
`endif
        end
    endtask

    task automatic doReload(input string tag);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        checkOutput({tag, "_reload_cpu_reset"}, 64'(cpu_reset), 64'd1);
        checkOutput({tag, "_reload_done"}, 64'(done), 64'd0);
        checkOutput({tag, "_reload_error"}, 64'(error), 64'd0);
        checkOutput({tag, "_reload_in_ready"}, 64'(in_ready), 64'd1);
        clearMonitor();
    endtask

    initial begin
        int wrAtReset;

        // Reset values while reset is held, then release.
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("por");
        reset = 1'b0;
        @(posedge clk);
        #1;
        clearMonitor();

        // Directed two-word image at full rate.
        img = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef BOOT_LOADER_CHECKSUM_EN
        appendChecksum();
`endif
        sendImage(0);
        checkLoad("full_rate");

        // Same image with random valid gaps.
        doReload("gaps");
        sendImage(3);
        checkLoad("gaps");

        // Random images of assorted lengths.
        for (int k = 0; k < 4; k++) begin
            doReload($sformatf("rand%0d", k));
            makeImage(int'($urandom_range(8, 1)));
            sendImage(k);
            checkLoad($sformatf("rand%0d", k));
        end

        // Oversized header is rejected and further bytes are ignored.
        doReload("oversize");
        img = {8'h10, 8'h01};
        sendImage(0);
        for (int k = 0; k < 3; k++) applyStimulus(8'($urandom_range(255, 0)), 0, 1'b0);
        checkLoad("oversize");

        doReload("after_err");
        makeImage(3);
        sendImage(1);
        checkLoad("after_err");

        // Reset in the middle of the payload.
        doReload("midreset");
        makeImage(3);
        for (int i = 0; i < 5; i++) applyStimulus(img[i], 0, 1'b1);
        reset = 1'b1;
        #1;
        checkResetValues("midreset");
        wrAtReset = wAddrQ.size();
        checkOutput("midreset_pre_writes", 64'(wrAtReset), 64'(3 / BPW));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("midreset_no_write_after", 64'(wAddrQ.size()), 64'(wrAtReset));
        reset = 1'b0;
        @(posedge clk);
        #1;
        clearMonitor();
        makeImage(2);
        sendImage(2);
        checkLoad("fresh_after_reset");

        // Empty image releases the CPU without any write.
        doReload("empty");
        img = {8'h00, 8'h00};
`ifdef BOOT_LOADER_CHECKSUM_EN
        appendChecksum();
`endif
        sendImage(0);
        checkLoad("empty");

`ifdef BOOT_LOADER_CHECKSUM_EN
        doReload("cs_good");
        img = {8'h00, 8'h01, 8'h12, 8'h34, 8'hB9};
        sendImage(0);
        checkLoad("cs_good");

        doReload("cs_bad");
        img = {8'h00, 8'h01, 8'h12, 8'h34, 8'hB8};
        sendImage(0);
        checkLoad("cs_bad");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/boot_loader.md
# boot_loader

Synthesisable program loader that replaces file-based memory preloading. It receives a program image as a byte stream (from a UART receiver or a bench driver), assembles bytes into memory words and writes them into the single-port program memory from address 0. It holds the CPU in reset until the image is complete and a programmable release delay has expired. It sits between the byte source, the `memory` write port and the `cpu` reset input.

## Interface
- `MEM_DEPTH`, 4096: memory words; must be ≤ 65536.
- `ADDR_WIDTH`, $clog2(MEM_DEPTH): memory address width.
- `DATA_WIDTH`, 16: memory word width; a multiple of 8, from 8 to 64.
- `RELEASE_DELAY`, 2: cycles from the last write to CPU reset release; must be ≥ 1.

- `clk` in 1: the single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: byte-stream valid.
- `in_data` in 8: stream byte.
- `in_ready` out 1: loader can accept a byte.
- `reload` in 1: restarts loading; honoured only in RUN and ERROR.
- `mem_en` out 1: memory enable for a write.
- `mem_wr_en` out 1: memory write strobe.
- `mem_addr` out ADDR_WIDTH: write address.
- `mem_din` out DATA_WIDTH: write data.
- `cpu_reset` out 1: active-high CPU reset.
- `done` out 1: image loaded and CPU released.
- `error` out 1: image rejected.

## Operation
- Image format:
  - 16-bit word count N, sent big-endian.
  - N words of DATA_WIDTH/8 bytes each, most significant byte first.
  - One checksum byte, only when the checksum feature is compiled in.
- States: HDR_HI → HDR_LO → DATA → (CHECK) → HOLD → RUN, plus ERROR.
- `in_ready` = 1 in HDR_HI, HDR_LO, DATA and CHECK; 0 elsewhere. A byte transfers when `in_valid && in_ready`.
- HDR_LO with a completed count:
  - N > MEM_DEPTH → ERROR.
  - N = 0 → CHECK if the feature is compiled in, otherwise HOLD.
  - Otherwise → DATA.
- DATA:
  - Shift accepted bytes into the assembly register.
  - On the final byte of a word, issue one write at the current address, then increment the address.
  - After write N, go to CHECK or HOLD.
- HOLD: count RELEASE_DELAY cycles, then go to RUN.
- RUN: `cpu_reset` = 0 and `done` = 1.
- ERROR: `cpu_reset` = 1 and `error` = 1; all further bytes are ignored.
- `reload` in RUN or ERROR:
  - Next state is HDR_HI.
  - Address, byte and word counters and the checksum are cleared.
  - `cpu_reset` rises on the same edge.
- Memory contents are never cleared by the loader.
- Outputs after reset:
  - `cpu_reset` = 1; `in_ready` = 1.
  - `mem_en` = `mem_wr_en` = 0.
  - `mem_addr` = 0; `mem_din` = 0.
  - `done` = 0; `error` = 0.
  - State = HDR_HI.

## Timing
- All outputs are registered.
- Write latency: `mem_en`/`mem_wr_en` pulse high for exactly one cycle, in the cycle after the final byte of a word is accepted. `mem_addr` and `mem_din` are valid in that same cycle.
- Back-to-back full-rate bytes are supported with no bubbles, so `in_ready` never deasserts during DATA.
- Release: `cpu_reset` falls RELEASE_DELAY cycles after the last write pulse (or after the header/checksum when N = 0). `done` rises in the same cycle.
- Gaps in `in_valid` only stall progress; partial word state is kept.
- Reset asserted mid-image: everything aborts immediately. No write pulse occurs after reset asserts.
- `reload` asserted together with `reset`: reset wins.

## Configuration
- Macro `BOOT_LOADER_CHECKSUM_EN`, defined:
  - The CHECK state accepts a trailing byte.
  - The 8-bit modulo-256 sum of every image byte (header, payload and checksum) must be 0x00.
  - Mismatch → ERROR, and `cpu_reset` stays high.
  - Data words are still written during DATA; only release is gated.
- Macro undefined:
  - No CHECK state and no checksum byte.
  - DATA (or HDR_LO when N = 0) goes directly to HOLD.

## Structure
- Package `boot_loader_pkg` holds:
  - `boot_state_t` enum.
  - `HDR_BYTES` = 2.
  - `CHECKSUM_WIDTH` = 8.
- Sub-module `byte_packer`, parametrised by DATA_WIDTH:
  - Shift register and byte counter.
  - Emits a one-cycle `word_valid` with the assembled word.
- The top level holds the FSM, address counter, release counter and checksum.

## Test plan
- DATA_WIDTH=16, stream 00 02 12 34 AB CD at full rate:
  - Write pulses to addr 0 = 0x1234 and addr 1 = 0xABCD.
  - `cpu_reset` falls and `done` rises 2 cycles after the second pulse.
- Same image with random 0–3 cycle `in_valid` gaps → identical writes. No extra or duplicate `mem_wr_en` pulses.
- Header 10 01 with MEM_DEPTH=4096:
  - `error` = 1, `in_ready` = 0, no writes, `cpu_reset` stays 1.
  - Then `reload` plus a valid image → normal load.
- `reset` asserted after 3 payload bytes:
  - All outputs return to their reset values within the same cycle.
  - A fresh image loads starting at addr 0.
- With `BOOT_LOADER_CHECKSUM_EN`:
  - Stream 00 01 12 34 B9 → `done` = 1.
  - Stream 00 01 12 34 B8 → `error` = 1, `cpu_reset` stays 1.
- Header 00 00 → no writes; `cpu_reset` falls RELEASE_DELAY cycles after the header (or after the checksum byte).
